// File: rtl/collector_ofifo_drain_if.sv
// Collector FIFO pop port plus the AXI-Stream egress, bundled for the drain block.
// master = drain side (pops the FIFO, drives the stream); slave = FIFO/sink side.
interface collector_ofifo_drain_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  ofifo_rdy;
    logic                  ofifo_ren;
    logic [DATA_WIDTH-1:0] ofifo_rdata;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        input  ofifo_rdy,
        input  ofifo_rdata,
        input  m_tready,
        output ofifo_ren,
        output m_tdata,
        output m_tvalid,
        output m_tlast
    );

    modport slave (
        output ofifo_rdy,
        output ofifo_rdata,
        output m_tready,
        input  ofifo_ren,
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast
    );
endinterface

// File: rtl/collector_ofifo_drain.sv
// Drains the collector output FIFO into an AXI-Stream master, tlast every FRAME_LEN beats.
// Latency ren->tvalid 2 clk; 2-entry skid buffer absorbs the in-flight read under backpressure.
module collector_ofifo_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int FRAME_LEN  = 16,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    collector_ofifo_drain_if.master io,
    output logic [CNT_W-1:0]        frame_count,
    output logic                    busy
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;

    logic                  tvalid;
    logic                  tlast;
    logic                  pop;
    logic                  push;
    logic                  ren;
    logic [2:0]            pending;
    logic [1:0]            occ_after_pop;

    always_comb begin
        tvalid  = (occ_q != 2'd0);
        tlast   = tvalid & (beat_idx_q == LAST_IDX);
        pop     = tvalid & io.m_tready;
        push    = inflight_q;
        // Words already owed to the buffer; a new read is only issued if it will have a slot.
        pending = {1'b0, occ_q} + {2'b00, inflight_q};
        ren     = reset & enable & io.ofifo_rdy & (pending <= (3'd1 + {2'b00, pop}));
    end

    always_comb begin
        buf_d         = buf_q;
        occ_after_pop = occ_q - {1'b0, pop};
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (push) begin
            buf_d[occ_after_pop[0]] = io.ofifo_rdata;
        end
        occ_d      = occ_after_pop + {1'b0, push};
        inflight_d = ren;
    end

    always_comb begin
        beat_idx_d  = beat_idx_q;
        frame_cnt_d = frame_cnt_q;
        if (pop) begin
            if (tlast) begin
                beat_idx_d  = '0;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
                beat_idx_d  = beat_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            buf_q       <= '0;
            beat_idx_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            buf_q       <= buf_d;
            beat_idx_q  <= beat_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign io.ofifo_ren = ren;
    assign io.m_tdata   = word_t'(buf_q[0]);
    assign io.m_tvalid  = tvalid;
    assign io.m_tlast   = tlast;
    assign frame_count  = frame_cnt_q;
    assign busy         = tvalid | inflight_q;

    // The ren gating means a returning word always finds at most one entry occupied.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(inflight_q && (occ_q == 2'd2)));

endmodule

// File: tb/tb_collector_ofifo_drain.sv
// Bench for collector_ofifo_drain: FIFO source model, in-order scoreboard and frame arithmetic.
module tb_collector_ofifo_drain;
    localparam int DW = 64;
    localparam int FL = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [CW-1:0] frame_count;
    logic          busy;

    collector_ofifo_drain_if #(.DATA_WIDTH(DW)) bus();

    collector_ofifo_drain #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .io          (bus),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int            beat_total;
    bit            rdy_en;
    bit            ren_s;
    bit            stall_prev;
    logic [DW-1:0] stall_dat;
    int            n_cmp;
    int            n_err;

    task automatic upd_rdy();
        bus.ofifo_rdy = rdy_en && (src_q.size() != 0);
    endtask

    // Collector FIFO: a pop sampled at an edge returns its word right after that edge.
    initial begin
        bus.ofifo_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ren_s) begin
                n_cmp++;
                if (src_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fifo_underflow: ren=1 with empty FIFO, required ren=0");
                end else begin
                    bus.ofifo_rdata = src_q.pop_front();
                    exp_q.push_back(bus.ofifo_rdata);
                end
            end else begin
                bus.ofifo_rdata = {$urandom, $urandom};
            end
            upd_rdy();
        end
    end

    // Stream scoreboard: order, tlast position, frame count, busy and outstanding words.
    initial begin
        forever begin
            @(negedge clk);
            ren_s = bus.ofifo_ren;
            if (reset === 1'b1) begin
                n_cmp++;
                if (busy !== (exp_q.size() != 0)) begin
                    n_err++;
                    $display("FAIL busy: got %b required %b", busy, exp_q.size() != 0);
                end
                n_cmp++;
                if (exp_q.size() > 2) begin
                    n_err++;
                    $display("FAIL outstanding: got %0d words required <= 2", exp_q.size());
                end
                n_cmp++;
                if (frame_count !== CW'(beat_total / FL)) begin
                    n_err++;
                    $display("FAIL frame_count: got %0d required %0d", frame_count, beat_total / FL);
                end
                if (bus.m_tvalid === 1'b1) begin
                    if (stall_prev) begin
                        n_cmp++;
                        if (bus.m_tdata !== stall_dat) begin
                            n_err++;
                            $display("FAIL tdata_stable: got %h required %h", bus.m_tdata, stall_dat);
                        end
                    end
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL spurious_beat: got tdata %h required no beat", bus.m_tdata);
                    end else if (bus.m_tdata !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL tdata: got %h required %h", bus.m_tdata, exp_q[0]);
                    end
                    n_cmp++;
                    if (bus.m_tlast !== ((beat_total % FL) == FL - 1)) begin
                        n_err++;
                        $display("FAIL tlast: beat %0d got %b required %b", beat_total,
                                 bus.m_tlast, (beat_total % FL) == FL - 1);
                    end
                    if (bus.m_tready === 1'b1) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        beat_total++;
                        stall_prev = 1'b0;
                    end else begin
                        stall_prev = 1'b1;
                        stall_dat  = bus.m_tdata;
                    end
                end else begin
                    n_cmp++;
                    if (stall_prev || bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin
                        n_err++;
                        $display("FAIL valid_idle: tvalid=%b tlast=%b stalled=%b required tvalid held / tlast 0",
                                 bus.m_tvalid, bus.m_tlast, stall_prev);
                    end
                    stall_prev = 1'b0;
                end
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        beat_total = 0;
        stall_prev = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset        = 1'b0;
        enable       = 1'b0;
        bus.m_tready = 1'b0;
        rdy_en       = 1'b0;
        src_q.delete();
        clear_model();
        upd_rdy();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (beat_total < n && cyc < budget) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        n_cmp++;
        if (beat_total < n) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d beats required %0d", name, beat_total, n);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp++;
        if (bus.ofifo_ren !== 1'b0 || bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0 ||
            frame_count !== '0 || busy !== 1'b0 || bus.m_tdata !== '0) begin
            n_err++;
            $display("FAIL %s: ren=%b tvalid=%b tlast=%b fc=%0d busy=%b tdata=%h required all 0",
                     name, bus.ofifo_ren, bus.m_tvalid, bus.m_tlast, frame_count, busy, bus.m_tdata);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        enable       = 1'b1;
        bus.m_tready = 1'b1;
        rdy_en       = 1'b1;
        src_q.push_back(64'hdead_beef);
        upd_rdy();
        #1;
        check_zero_outputs("reset_t0");
        repeat (2) @(posedge clk);
        #2;
        check_zero_outputs("reset_held");
    endtask

    task automatic test_streaming();
        int lat;
        apply_reset();
        for (int i = 1; i <= 32; i++) src_q.push_back(DW'(i));
        rdy_en       = 1'b1;
        bus.m_tready = 1'b1;
        upd_rdy();
        @(posedge clk);
        #2;
        enable = 1'b1;
        #1;
        n_cmp++;
        if (bus.ofifo_ren !== 1'b1) begin
            n_err++;
            $display("FAIL stream_ren: got %b required 1", bus.ofifo_ren);
        end
        lat = 0;
        while (bus.m_tvalid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #2;
            lat++;
        end
        n_cmp++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL stream_latency: got %0d clk required 2", lat);
        end
        repeat (32) @(posedge clk);
        #2;
        n_cmp++;
        if (beat_total != 32 || frame_count !== CW'(2) || bus.m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_rate: beats=%0d fc=%0d tvalid=%b required 32 / 2 / 0",
                     beat_total, frame_count, bus.m_tvalid);
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int cyc;
        apply_reset();
        for (int i = 0; i < 40; i++) src_q.push_back({$urandom, $urandom});
        rdy_en = 1'b1;
        upd_rdy();
        @(posedge clk);
        #2;
        enable = 1'b1;
        cyc = 0;
        while (beat_total < 40 && cyc < 400) begin
            bus.m_tready = pat[cyc % 4];
            @(posedge clk);
            #2;
            cyc++;
        end
        n_cmp++;
        if (beat_total != 40 || src_q.size() != 0 || frame_count !== CW'(2)) begin
            n_err++;
            $display("FAIL backpressure: beats=%0d left=%0d fc=%0d required 40 / 0 / 2",
                     beat_total, src_q.size(), frame_count);
        end
    endtask

    task automatic test_empty_fifo();
        apply_reset();
        for (int i = 0; i < 5; i++) src_q.push_back({$urandom, $urandom});
        rdy_en       = 1'b1;
        bus.m_tready = 1'b1;
        upd_rdy();
        @(posedge clk);
        #2;
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        n_cmp++;
        if (beat_total != 5 || bus.m_tvalid !== 1'b0 || busy !== 1'b0 || bus.ofifo_ren !== 1'b0) begin
            n_err++;
            $display("FAIL empty_fifo: beats=%0d tvalid=%b busy=%b ren=%b required 5 / 0 / 0 / 0",
                     beat_total, bus.m_tvalid, busy, bus.ofifo_ren);
        end
        for (int i = 0; i < 11; i++) src_q.push_back({$urandom, $urandom});
        upd_rdy();
        wait_beats(16, 100, "refill");
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (frame_count !== CW'(1) || beat_total != 16) begin
            n_err++;
            $display("FAIL refill_frame: fc=%0d beats=%0d required 1 / 16", frame_count, beat_total);
        end
    endtask

    task automatic test_enable_gap();
        logic [DW-1:0] first;
        int cyc;
        apply_reset();
        for (int i = 0; i < 10; i++) src_q.push_back({$urandom, $urandom});
        first  = src_q[0];
        rdy_en = 1'b1;
        upd_rdy();
        @(posedge clk);
        #2;
        enable = 1'b1;
        @(posedge clk);
        #2;
        enable = 1'b0;
        #1;
        n_cmp++;
        if (bus.ofifo_ren !== 1'b0 || exp_q.size() != 1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL gap_stop: ren=%b inflight=%0d busy=%b required 0 / 1 / 1",
                     bus.ofifo_ren, exp_q.size(), busy);
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== first) begin
            n_err++;
            $display("FAIL gap_capture: tvalid=%b tdata=%h required 1 / %h", bus.m_tvalid, bus.m_tdata, first);
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (bus.ofifo_ren !== 1'b0 || bus.m_tvalid !== 1'b1 || src_q.size() != 9) begin
            n_err++;
            $display("FAIL gap_hold: ren=%b tvalid=%b fifo_left=%0d required 0 / 1 / 9",
                     bus.ofifo_ren, bus.m_tvalid, src_q.size());
        end
        bus.m_tready = 1'b1;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 10) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        n_cmp++;
        if (busy !== 1'b0 || beat_total != 1 || src_q.size() != 9) begin
            n_err++;
            $display("FAIL gap_drain: busy=%b beats=%0d fifo_left=%0d required 0 / 1 / 9",
                     busy, beat_total, src_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] first;
        int cyc;
        apply_reset();
        for (int i = 0; i < 30; i++) src_q.push_back({$urandom, $urandom});
        rdy_en       = 1'b1;
        bus.m_tready = 1'b1;
        upd_rdy();
        @(posedge clk);
        #2;
        enable = 1'b1;
        cyc = 0;
        while (beat_total < 7 && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        bus.m_tready = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_cmp++;
        if (beat_total != 7 || exp_q.size() != 2 || bus.m_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL arst_setup: beats=%0d held=%0d tvalid=%b required 7 / 2 / 1",
                     beat_total, exp_q.size(), bus.m_tvalid);
        end
        reset = 1'b0;
        clear_model();
        #1;
        check_zero_outputs("arst_immediate");
        first = src_q[0];
        bus.m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        cyc = 0;
        while (bus.m_tvalid !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        n_cmp++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== first || bus.m_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL arst_first_beat: tvalid=%b tdata=%h tlast=%b required 1 / %h / 0",
                     bus.m_tvalid, bus.m_tdata, bus.m_tlast, first);
        end
        wait_beats(FL, 100, "arst_frame");
        @(posedge clk);
        #2;
        n_cmp++;
        if (frame_count !== CW'(beat_total / FL)) begin
            n_err++;
            $display("FAIL arst_frame_count: got %0d required %0d", frame_count, beat_total / FL);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        ren_s        = 1'b0;
        stall_prev   = 1'b0;
        beat_total   = 0;
        reset        = 1'b0;
        enable       = 1'b0;
        rdy_en       = 1'b0;
        bus.m_tready = 1'b0;
        bus.ofifo_rdy = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_fifo();
        test_enable_gap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
